// File: rtl/vram_arbiter.sv
// Single-port page RAM shared between ULA video fetches and the Z80 bus.
// Video has absolute priority; CPU writes are posted through a one-entry buffer.
module vram_arbiter #(
   parameter int AW        = 17,
   parameter int PAGE_SCR0 = 5,
   parameter int PAGE_SCR1 = 7
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          bank_sel,
   input  logic          vid_req,
   input  logic [12:0]   vid_addr,
   output logic [7:0]    vid_data,
   output logic          vid_valid,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_ack,
   output logic [7:0]    cpu_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          mem_we,
   input  logic [7:0]    mem_rdata
);

   localparam logic [AW-1:0] BASE0 = AW'(PAGE_SCR0 * 16384);
   localparam logic [AW-1:0] BASE1 = AW'(PAGE_SCR1 * 16384);

   logic          buf_full;
   logic [AW-1:0] buf_addr;
   logic [7:0]    buf_data;

   logic t1_vid, t2_vid;
   logic t1_cpu, t2_cpu;

   logic          cpu_busy;
   logic          cpu_live;
   logic          drain;
   logic          fwd_hit;
   logic          rd_go;
   logic          wr_go;
   logic [AW-1:0] vid_pa;

   // A CPU request is live only when no ack is showing and no read is in flight
   always_comb begin
      cpu_busy = t1_cpu | t2_cpu;
      cpu_live = cpu_req & ~cpu_ack & ~cpu_busy;
      drain    = buf_full & ~vid_req;
      fwd_hit  = cpu_live & ~cpu_we & buf_full & (cpu_addr == buf_addr);
      rd_go    = cpu_live & ~cpu_we & ~vid_req & ~buf_full;
      wr_go    = cpu_live & cpu_we & (~buf_full | drain);
      vid_pa   = (bank_sel ? BASE1 : BASE0) + AW'(vid_addr);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         buf_full  <= 1'b0;
         buf_addr  <= '0;
         buf_data  <= '0;
         t1_vid    <= 1'b0;
         t2_vid    <= 1'b0;
         t1_cpu    <= 1'b0;
         t2_cpu    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         vid_data  <= '0;
         vid_valid <= 1'b0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         t1_vid <= vid_req;
         t2_vid <= t1_vid;
         t1_cpu <= rd_go;
         t2_cpu <= t1_cpu;

         mem_we <= 1'b0;
         priority case (1'b1)
            vid_req: mem_addr <= vid_pa;
            buf_full: begin
               mem_addr  <= buf_addr;
               mem_wdata <= buf_data;
               mem_we    <= 1'b1;
            end
            rd_go:   mem_addr <= cpu_addr;
            default: ;
         endcase

         // Accepting a write in the drain cycle refills the buffer at once
         if (wr_go) begin
            buf_full <= 1'b1;
            buf_addr <= cpu_addr;
            buf_data <= cpu_wdata;
         end else if (drain) begin
            buf_full <= 1'b0;
         end

         vid_valid <= t2_vid;
         if (t2_vid) vid_data <= mem_rdata;

         cpu_ack <= wr_go | fwd_hit | t2_cpu;
         if (fwd_hit)     cpu_rdata <= buf_data;
         else if (t2_cpu) cpu_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;
   localparam int AW = 17;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          bank_sel = 1'b0;
   logic          vid_req = 1'b0;
   logic [12:0]   vid_addr = '0;
   logic [7:0]    vid_data;
   logic          vid_valid;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_wdata = '0;
   logic          cpu_ack;
   logic [7:0]    cpu_rdata;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_we;
   logic [7:0]    mem_rdata = '0;

   logic [7:0] ram [0:(1<<AW)-1];

   typedef struct packed {
      logic       rd;
      logic [7:0] d;
   } cpu_exp_t;

   logic [7:0]    vid_q[$];
   cpu_exp_t      cpu_q[$];
   int            we_cyc_q[$];
   logic [AW-1:0] we_addr_q[$];
   cpu_exp_t      mon_e;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int vv_cnt = 0;
   int vv_last = -1;
   int ack_cnt = 0;
   int watch_cyc = -1;
   logic [AW-1:0] watch_addr = '1;

   vram_arbiter #(.AW(AW), .PAGE_SCR0(5), .PAGE_SCR1(7)) dut (
      .clock(clock), .reset(reset), .bank_sel(bank_sel),
      .vid_req(vid_req), .vid_addr(vid_addr),
      .vid_data(vid_data), .vid_valid(vid_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #20 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic expect_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] pat(input logic [AW-1:0] a);
      return a[7:0] ^ {a[16:13], a[11:8]} ^ 8'h5C;
   endfunction

   function automatic int we_c(input int i);
      return (i < we_cyc_q.size()) ? we_cyc_q[i] : -1;
   endfunction

   function automatic logic [AW-1:0] we_a(input int i);
      return (i < we_addr_q.size()) ? we_addr_q[i] : '1;
   endfunction

   always @(negedge clock) begin
      if (!reset) begin
         if (vid_valid) begin
            vv_cnt++;
            vv_last = cyc;
            if (vid_q.size() == 0) expect_eq("vid_unexpected", 1, 0);
            else expect_eq("vid_data", vid_data, vid_q.pop_front());
         end
         if (cpu_ack) begin
            ack_cnt++;
            if (cpu_q.size() == 0) expect_eq("ack_unexpected", 1, 0);
            else begin
               mon_e = cpu_q.pop_front();
               if (mon_e.rd) expect_eq("cpu_rdata", cpu_rdata, mon_e.d);
            end
         end
         if (mem_we) begin
            we_cyc_q.push_back(cyc);
            we_addr_q.push_back(mem_addr);
         end
         if (!mem_we && mem_addr == watch_addr && watch_cyc < 0)
            watch_cyc = cyc;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_ack(output int ack_c);
      int n;
      n = 0;
      ack_c = -1;
      while (n < 300 && ack_c < 0) begin
         @(negedge clock);
         if (cpu_ack) ack_c = cyc;
         n++;
      end
      if (ack_c < 0) expect_eq("cpu_ack_timeout", 0, 1);
      @(posedge clock);
      #1;
      cpu_req = 1'b0;
   endtask

   task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d,
                            output int ack_c);
      cpu_exp_t e;
      e.rd = 1'b0;
      e.d  = d;
      cpu_q.push_back(e);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      wait_ack(ack_c);
   endtask

   task automatic cpu_read(input logic [AW-1:0] a, input logic [7:0] d,
                           output int issue_c, output int ack_c);
      cpu_exp_t e;
      e.rd = 1'b1;
      e.d  = d;
      cpu_q.push_back(e);
      issue_c = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      wait_ack(ack_c);
   endtask

   task automatic vid_burst(input int n, input logic [12:0] base,
                            output int last_c);
      logic [AW-1:0] pa;
      last_c = -1;
      for (int i = 0; i < n; i++) begin
         vid_req  = 1'b1;
         vid_addr = base + 13'(i);
         pa = AW'((bank_sel ? 7 : 5) * 16384) + AW'(vid_addr);
         vid_q.push_back(pat(pa));
         last_c = cyc;
         tick();
      end
      vid_req = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int c0, a1, a2, ic, lc, w0, v0, k0;
      for (int i = 0; i < (1 << AW); i++) ram[i] = pat(AW'(i));

      // reset state
      reset = 1'b1;
      tick(2);
      expect_eq("rst_mem_addr", mem_addr, 0);
      expect_eq("rst_mem_we", mem_we, 0);
      expect_eq("rst_vid_valid", vid_valid, 0);
      expect_eq("rst_cpu_ack", cpu_ack, 0);
      reset = 1'b0;
      tick(2);

      // video latency and page mapping
      ram[17'h1C123] = 8'hA5;
      ram[17'h14123] = 8'h5A;
      bank_sel = 1'b1;
      vid_req = 1'b1; vid_addr = 13'h0123;
      vid_q.push_back(8'hA5);
      c0 = cyc; v0 = vv_cnt;
      tick();
      vid_req = 1'b0;
      expect_eq("t1_mem_addr_scr1", mem_addr, 17'h1C123);
      tick(4);
      expect_eq("t1_vv_cycle", vv_last, c0 + 3);
      expect_eq("t1_vv_count", vv_cnt - v0, 1);

      bank_sel = 1'b0;
      vid_req = 1'b1; vid_addr = 13'h0123;
      vid_q.push_back(8'h5A);
      v0 = vv_cnt;
      tick();
      vid_req = 1'b0;
      bank_sel = 1'b1;
      expect_eq("t1_mem_addr_scr0", mem_addr, 17'h14123);
      tick(4);
      expect_eq("t1_vv_count0", vv_cnt - v0, 1);
      bank_sel = 1'b0;

      // posted write then read-back
      w0 = we_cyc_q.size();
      cpu_write(17'h00200, 8'h3F, a1);
      expect_eq("t2_mem_we", mem_we, 1);
      expect_eq("t2_mem_addr", mem_addr, 17'h00200);
      expect_eq("t2_mem_wdata", mem_wdata, 8'h3F);
      cpu_read(17'h00200, 8'h3F, ic, a2);
      tick(2);
      expect_eq("t2_read_latency", a2 - ic, 3);
      expect_eq("t2_we_count", we_cyc_q.size() - w0, 1);

      // priority and forwarding under a video burst
      w0 = we_cyc_q.size(); v0 = vv_cnt;
      fork
         vid_burst(20, 13'h0400, lc);
         begin
            cpu_write(17'h05000, 8'h11, a1);
            cpu_read(17'h05000, 8'h11, ic, a2);
         end
      join
      tick(6);
      expect_eq("t3_wr_ack_in_burst", a1 <= lc, 1);
      expect_eq("t3_fwd_latency", a2 - ic, 1);
      expect_eq("t3_vv_count", vv_cnt - v0, 20);
      expect_eq("t3_we_count", we_cyc_q.size() - w0, 1);
      expect_eq("t3_we_after_burst", we_c(w0) > lc, 1);

      // full buffer stall
      w0 = we_cyc_q.size(); k0 = ack_cnt;
      fork
         vid_burst(10, 13'h0800, lc);
         begin
            cpu_write(17'h06000, 8'h22, a1);
            cpu_write(17'h06001, 8'h33, a2);
         end
      join
      tick(4);
      expect_eq("t4_first_drain_addr", we_a(w0), 17'h06000);
      expect_eq("t4_ack2_after_drain", a2 >= we_c(w0) && we_c(w0) >= 0, 1);
      expect_eq("t4_ack2_after_burst", a2 > lc, 1);
      expect_eq("t4_ack_count", ack_cnt - k0, 2);
      expect_eq("t4_second_drain_addr", we_a(w0 + 1), 17'h06001);
      cpu_read(17'h06001, 8'h33, ic, a2);

      // reset mid-flight
      ram[17'h07000] = 8'h44;
      tick();
      v0 = vv_cnt; w0 = we_cyc_q.size();
      mon_e.rd = 1'b0; mon_e.d = 8'h99;
      cpu_q.push_back(mon_e);
      vid_req = 1'b1; vid_addr = 13'h0010; bank_sel = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h07000; cpu_wdata = 8'h99;
      tick();
      cpu_req = 1'b0;
      tick();
      vid_req = 1'b0;
      reset = 1'b1;
      #1;
      expect_eq("t5_rst_mem_addr", mem_addr, 0);
      expect_eq("t5_rst_mem_we", mem_we, 0);
      expect_eq("t5_rst_vid_data", vid_data, 0);
      expect_eq("t5_rst_cpu_ack", cpu_ack, 0);
      vid_q.delete();
      cpu_q.delete();
      tick(2);
      reset = 1'b0;
      tick(6);
      expect_eq("t5_no_vv", vv_cnt - v0, 0);
      expect_eq("t5_no_we", we_cyc_q.size() - w0, 0);
      expect_eq("t5_ram_kept", ram[17'h07000], 8'h44);
      cpu_read(17'h07000, 8'h44, ic, a2);

      // memory order follows CPU order
      ram[17'h01000] = 8'h77;
      watch_addr = 17'h01000; watch_cyc = -1;
      w0 = we_cyc_q.size();
      fork
         vid_burst(6, 13'h0C00, lc);
         begin
            cpu_write(17'h02000, 8'h55, a1);
            cpu_read(17'h01000, 8'h77, ic, a2);
         end
      join
      tick(3);
      expect_eq("t6_drain_addr", we_a(w0), 17'h02000);
      expect_eq("t6_read_seen", watch_cyc >= 0, 1);
      expect_eq("t6_drain_first", we_c(w0) >= 0 && we_c(w0) < watch_cyc, 1);
      expect_eq("t6_ram_written", ram[17'h02000], 8'h55);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Memory-side responder for the ULA's video fetches, which are the VRAM reads from the 128K page RAM.
- Shares one single-port synchronous RAM between the video reader and the Z80 bus.
- Video reads have absolute priority and a fixed latency.
- CPU writes are posted through a one-entry write buffer. CPU reads use a req/ack handshake, with forwarding from the buffer.

Parameters:
- AW, 17, physical RAM address width (128K).
- PAGE_SCR0, 5, 16K page holding screen 0 (bank_sel=0).
- PAGE_SCR1, 7, 16K page holding screen 1 (bank_sel=1).

Ports:
- clock      in   1   system clock, 25 MHz
- reset      in   1   asynchronous, active-high
- bank_sel   in   1   screen select (port7ffd[3])
- vid_req    in   1   video read strobe, one per cycle max
- vid_addr   in   13  offset within screen page
- vid_data   out  8   video read data
- vid_valid  out  1   vid_data valid, one-cycle pulse
- cpu_req    in   1   CPU request, level, held until cpu_ack
- cpu_we     in   1   1=write, 0=read
- cpu_addr   in   17  physical address
- cpu_wdata  in   8   write data
- cpu_ack    out  1   one-cycle completion pulse
- cpu_rdata  out  8   read data, valid while cpu_ack=1
- mem_addr   out  17  RAM address, registered
- mem_wdata  out  8   RAM write data, registered
- mem_we     out  1   RAM write enable, registered
- mem_rdata  in   8   RAM read data, valid the cycle after mem_addr is held

Behaviour:
- **Reset.** All outputs are 0. The write buffer is emptied and any pending write is discarded. In-flight read tags are cleared, so no vid_valid or cpu_ack is produced for pre-reset requests. Reset is effective immediately (async) and released synchronously.
- **Memory slot.** One access per cycle. Slot owner is chosen at each edge in this priority order:
  1. vid_req
  2. buffer drain, if the buffer is full
  3. CPU read, if cpu_req=1, cpu_we=0, no forward hit and cpu_ack=0
  4. idle
- **Video address.** The video physical address is page·16384 + vid_addr. The page is PAGE_SCR1 if bank_sel else PAGE_SCR0. bank_sel is sampled together with vid_req.
- **Read pipeline.** Tag pipe is issue → mem (mem_addr held) → capture (mem_rdata registered).
  - vid_req=1 in cycle c gives vid_valid=1 and vid_data in cycle c+3.
  - Video reads issued back-to-back every cycle are fully pipelined.
  - A CPU read issued at the end of cycle c gives cpu_ack=1 and cpu_rdata in cycle c+3.
- **Write acceptance.** cpu_req=1 and cpu_we=1 are accepted when the buffer is empty, or is draining in the same cycle. The buffer loads {addr, data} and cpu_ack=1 the next cycle, regardless of video traffic. A write arriving while the buffer is full and not draining waits; it is not acked.
- **Drain.** mem_addr/mem_wdata come from the buffer, with mem_we=1 for exactly that cycle. mem_we=0 on every read or idle cycle.
- **Forwarding.** A CPU read with cpu_addr equal to a full buffer's address returns the buffer data with cpu_ack in the next cycle and issues no memory access.
- **Handshake.**
  - cpu_req is ignored in the cycle cpu_ack=1, so one request gives exactly one ack.
  - Only one CPU transaction is outstanding at a time.
  - cpu_we/cpu_addr/cpu_wdata must stay stable while cpu_req=1 and un-acked.
- **Starvation.** Continuous vid_req starves the CPU indefinitely, with no timeout (the ULA issues ≤2 requests per 16 cycles).
- **Coherence.**
  - The drain occurs before any later CPU read to a different address is issued, so memory order equals CPU order.
  - Video reading an address with a pending buffered write sees the old RAM value. This is acceptable.
- **Widths.** Address arithmetic is AW bits. A page×16384 overflow beyond AW wraps modulo 2^AW.
- **Mid-transaction.** Changing bank_sel affects only subsequent vid_req.

Test Plan:
1. **Video read latency and page mapping.** reset, RAM[0x1C123]=0xA5, bank_sel=1, vid_req with vid_addr=0x0123 in cycle 10 → mem_addr=0x1C123 in cycle 11, vid_valid=1 and vid_data=0xA5 in cycle 13 only. With bank_sel=0 the same request gives mem_addr=0x14123.
2. **Posted write.** cpu write 0x3F to 0x00200 → cpu_ack next cycle, mem_we=1 with mem_addr=0x00200 and mem_wdata=0x3F one cycle later. A follow-up read of 0x00200 returns 0x3F with no extra mem_we.
3. **Priority and forwarding.** vid_req every cycle for 20 cycles while cpu writes 0x11 to 0x05000 and then reads 0x05000:
   - the write is acked during the video burst;
   - the read is forwarded, giving 0x11 one cycle after issue;
   - mem_we stays 0 until the burst ends;
   - exactly 20 vid_valid pulses occur.
4. **Full buffer stall.** Two back-to-back writes while vid_req is continuous → the second cpu_ack appears only after the first drain cycle (mem_we=1). Each write produces exactly one ack.
5. **Reset mid-flight.** Assert reset one cycle after vid_req and while a write is buffered → no vid_valid, no mem_we, all outputs 0. After release the RAM at the buffered address is unchanged.
6. **Read ordering after write.** cpu read 0x01000 (RAM=0x77) directly after a buffered write to 0x02000 → mem_we cycle for 0x02000 precedes the mem_addr=0x01000 read, and cpu_rdata=0x77.
